// File: rtl/calc_key_sequencer.sv
// Key sequencer for the BCD calculator: builds operands/op for the ALU, captures its result.
// Optional build macro CALC_CHAIN_RESULT_EN: an operator key in DONE chains the result into reg1.
module calc_key_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        key_ready,
   output logic [15:0] reg1,
   output logic [15:0] reg2,
   output logic        regop,
   input  logic [15:0] res_in,
   input  logic        ovf_in,
   input  logic        sign_in,
   output logic [15:0] disp,
   output logic        disp_sign,
   output logic        disp_err,
   output logic        result_valid,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      ENTRY1 = 3'd0,
      ENTRY2 = 3'd1,
      EXEC   = 3'd2,
      DONE   = 3'd3,
      ERR    = 3'd4
   } state_t;

   state_t      state, nxt_state;
   logic [2:0]  cnt, nxt_cnt;
   logic [3:0]  settle, nxt_settle;
   logic [15:0] nxt_reg1, nxt_reg2, nxt_disp;
   logic        nxt_regop, nxt_disp_sign, nxt_disp_err, nxt_result_valid;

   // Handshake: a key is consumed on a rising edge only when key_valid && key_ready; otherwise it is lost.
   logic accept, is_digit, is_op, op_add;
   assign accept   = key_valid & key_ready;
   assign is_digit = (key_code <= 4'd9);
   assign is_op    = (key_code == 4'hA) || (key_code == 4'hB);
   assign op_add   = (key_code == 4'hA);
   assign dbg_state = state;

   always_comb begin
      nxt_state        = state;
      nxt_cnt          = cnt;
      nxt_settle       = settle;
      nxt_reg1         = reg1;
      nxt_reg2         = reg2;
      nxt_regop        = regop;
      nxt_disp         = disp;
      nxt_disp_sign    = disp_sign;
      nxt_disp_err     = disp_err;
      nxt_result_valid = 1'b0;

      if (accept && key_code == 4'hD) begin
         nxt_state     = ENTRY1;
         nxt_cnt       = 3'd0;
         nxt_reg1      = 16'h0;
         nxt_reg2      = 16'h0;
         nxt_regop     = 1'b1;
         nxt_disp_sign = 1'b0;
         nxt_disp_err  = 1'b0;
      end else begin
         case (state)
            ENTRY1: if (accept) begin
               if (is_digit && cnt != 3'd4) begin
                  nxt_reg1 = {reg1[11:0], key_code};
                  nxt_cnt  = cnt + 3'd1;
               end else if (is_op) begin
                  nxt_regop = op_add;
                  nxt_reg2  = 16'h0;
                  nxt_cnt   = 3'd0;
                  nxt_state = ENTRY2;
               end
            end
            ENTRY2: if (accept) begin
               if (is_digit && cnt != 3'd4) begin
                  nxt_reg2 = {reg2[11:0], key_code};
                  nxt_cnt  = cnt + 3'd1;
               end else if (is_op && cnt == 3'd0) begin
                  nxt_regop = op_add;
               end else if (key_code == 4'hC) begin
                  nxt_state  = EXEC;
                  nxt_settle = 4'(SETTLE_CYCLES - 1);
               end
            end
            EXEC: begin
               if (settle == 4'd0) begin
                  nxt_result_valid = 1'b1;
                  nxt_disp         = res_in;
                  nxt_disp_sign    = sign_in & ~regop;
                  if (regop && ovf_in) begin
                     nxt_state    = ERR;
                     nxt_disp     = 16'h0;
                     nxt_disp_err = 1'b1;
                  end else begin
                     nxt_state = DONE;
                  end
               end else begin
                  nxt_settle = settle - 4'd1;
               end
            end
            DONE: if (accept) begin
               if (is_digit) begin
                  nxt_reg1      = {12'h0, key_code};
                  nxt_reg2      = 16'h0;
                  nxt_disp_sign = 1'b0;
                  nxt_cnt       = 3'd1;
                  nxt_state     = ENTRY1;
               end
`ifdef CALC_CHAIN_RESULT_EN
               else if (is_op && !disp_sign) begin
                  nxt_reg1  = disp;
                  nxt_regop = op_add;
                  nxt_reg2  = 16'h0;
                  nxt_cnt   = 3'd0;
                  nxt_state = ENTRY2;
               end
`endif
            end
            default: ;
         endcase
      end

      // Entry states always show the operand being typed (reg1 until reg2 has a digit).
      if (nxt_state == ENTRY1) begin
         nxt_disp = nxt_reg1;
      end else if (nxt_state == ENTRY2) begin
         nxt_disp = (nxt_cnt != 3'd0) ? nxt_reg2 : nxt_reg1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ENTRY1;
         cnt          <= 3'd0;
         settle       <= 4'd0;
         reg1         <= 16'h0;
         reg2         <= 16'h0;
         regop        <= 1'b1;
         disp         <= 16'h0;
         disp_sign    <= 1'b0;
         disp_err     <= 1'b0;
         result_valid <= 1'b0;
         key_ready    <= 1'b1;
      end else begin
         state        <= nxt_state;
         cnt          <= nxt_cnt;
         settle       <= nxt_settle;
         reg1         <= nxt_reg1;
         reg2         <= nxt_reg2;
         regop        <= nxt_regop;
         disp         <= nxt_disp;
         disp_sign    <= nxt_disp_sign;
         disp_err     <= nxt_disp_err;
         result_valid <= nxt_result_valid;
         key_ready    <= (nxt_state != EXEC);
      end
   end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with a behavioural BCD ALU model on the operand interface.
module tb_calc_key_sequencer;

   localparam logic [2:0] S_ENTRY1 = 3'd0;
   localparam logic [2:0] S_ENTRY2 = 3'd1;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERR    = 3'd4;
   localparam logic [3:0] K_ADD = 4'hA, K_SUB = 4'hB, K_EQ = 4'hC, K_CLR = 4'hD;

   logic        clk, rst_n, key_valid, key_ready, regop, ovf_in, sign_in;
   logic        disp_sign, disp_err, result_valid;
   logic [3:0]  key_code;
   logic [15:0] reg1, reg2, res_in, disp;
   logic [2:0]  dbg_state;
   int          n_checks, n_errors;
   int          m_a, m_b, m_s;
   logic [15:0] exp_q[$];

   calc_key_sequencer #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .reg1(reg1), .reg2(reg2), .regop(regop),
      .res_in(res_in), .ovf_in(ovf_in), .sign_in(sign_in), .disp(disp),
      .disp_sign(disp_sign), .disp_err(disp_err), .result_valid(result_valid),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: arithmetic on binary values, converted back to BCD
   function automatic int bcd2bin(input logic [15:0] v);
      return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] bin2bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'((n / 1000) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   always_comb begin
      m_a     = bcd2bin(reg1);
      m_b     = bcd2bin(reg2);
      ovf_in  = 1'b0;
      sign_in = 1'b0;
      if (regop) begin
         m_s    = m_a + m_b;
         ovf_in = (m_s > 9999);
         res_in = bin2bcd(m_s % 10000);
      end else if (m_a >= m_b) begin
         m_s    = m_a - m_b;
         res_in = bin2bcd(m_s);
      end else begin
         m_s     = m_b - m_a;
         sign_in = 1'b1;
         res_in  = bin2bcd(m_s);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic press(input logic [3:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'hF;
   endtask

   task automatic press_seq(input logic [3:0] seq[$]);
      foreach (seq[i]) press(seq[i]);
   endtask

   // Called right after '=' was accepted; any key left on the bus is dropped after one cycle.
   task automatic wait_result(input string tag, input int exp_lat);
      int n;
      logic [15:0] exp;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         key_valid = 1'b0;
         if (result_valid) break;
      end
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      check({tag, "_disp"}, {16'h0, disp}, {16'h0, exp});
      check({tag, "_ready"}, {31'h0, key_ready}, 32'h1);
      @(negedge clk);
      check({tag, "_pulse"}, {31'h0, result_valid}, 32'h0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_reg1"}, {16'h0, reg1}, 32'h0);
      check({tag, "_reg2"}, {16'h0, reg2}, 32'h0);
      check({tag, "_regop"}, {31'h0, regop}, 32'h1);
      check({tag, "_disp"}, {16'h0, disp}, 32'h0);
      check({tag, "_flags"}, {29'h0, disp_sign, disp_err, result_valid}, 32'h0);
      check({tag, "_ready"}, {31'h0, key_ready}, 32'h1);
      check({tag, "_state"}, {29'h0, dbg_state}, {29'h0, S_ENTRY1});
   endtask

   initial begin
      int rv_seen;
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'hF;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("rst");

      // 12 + 3
      press_seq('{4'd1, 4'd2});
      check("entry_12", {16'h0, disp}, 32'h0012);
      press(K_ADD);
      check("op_state", {29'h0, dbg_state}, {29'h0, S_ENTRY2});
      check("op_disp", {16'h0, disp}, 32'h0012);
      press(4'd3);
      check("entry2_disp", {16'h0, disp}, 32'h0003);
      exp_q.push_back(16'h0015);
      press(K_EQ);
      check("eq_ready_low", {31'h0, key_ready}, 32'h0);
      wait_result("add", 2);
      check("add_ops", {reg1, reg2}, {16'h0012, 16'h0003});
      check("add_regop", {31'h0, regop}, 32'h1);
      check("add_state", {29'h0, dbg_state}, {29'h0, S_DONE});

      // 3 - 8 with operator replacement and E/F ignored
      press(K_CLR);
      check_reset_vals("clr1");
      press_seq('{4'd3, 4'hE, K_SUB, K_ADD, K_SUB});
      check("op_replace", {31'h0, regop}, 32'h0);
      check("ef_ignored", {16'h0, reg1}, 32'h0003);
      press_seq('{4'd8, K_ADD});
      check("op_late_ignored", {31'h0, regop}, 32'h0);
      exp_q.push_back(16'h0005);
      press(K_EQ);
      wait_result("sub", 2);
      check("sub_sign", {31'h0, disp_sign}, 32'h1);

      // 9876 + 200 overflows
      press(K_CLR);
      press_seq('{4'd9, 4'd8, 4'd7, 4'd6, K_ADD, 4'd2, 4'd0, 4'd0});
      check("ovf_ops", {reg1, reg2}, {16'h9876, 16'h0200});
      exp_q.push_back(16'h0000);
      press(K_EQ);
      wait_result("ovf", 2);
      check("ovf_err", {30'h0, disp_err, disp_sign}, 32'h2);
      check("ovf_state", {29'h0, dbg_state}, {29'h0, S_ERR});
      press(4'd5);
      check("err_digit_ignored", {13'h0, dbg_state, disp}, {13'h0, S_ERR, 16'h0});
      press(K_CLR);
      check_reset_vals("clr_err");

      // fifth digit dropped; keys during EXEC dropped
      press_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
      check("cap4", {16'h0, reg1}, 32'h1234);
      press_seq('{K_ADD, 4'd1});
      exp_q.push_back(16'h1235);
      press(K_EQ);
      key_valid = 1'b1;
      key_code  = 4'd9;
      wait_result("exec_keys", 2);
      check("exec_ops", {reg1, reg2}, {16'h1234, 16'h0001});

      // digit in DONE starts a fresh expression
      press(4'd7);
      check("done_digit", {13'h0, dbg_state, reg1}, {13'h0, S_ENTRY1, 16'h0007});
      check("done_digit_disp", {reg2, disp}, {16'h0, 16'h0007});

      // operator in DONE
      press(K_CLR);
      press_seq('{4'd4, K_ADD, 4'd5});
      exp_q.push_back(16'h0009);
      press(K_EQ);
      wait_result("chain1", 2);
      press(K_ADD);
`ifdef CALC_CHAIN_RESULT_EN
      check("chain_state", {13'h0, dbg_state, reg1}, {13'h0, S_ENTRY2, 16'h0009});
      press(4'd1);
      exp_q.push_back(16'h0010);
      press(K_EQ);
      wait_result("chain2", 2);
      check("chain_ops", {reg1, reg2}, {16'h0009, 16'h0001});
`else
      check("nochain_state", {13'h0, dbg_state, reg1}, {13'h0, S_DONE, 16'h0004});
      press_seq('{4'd1, K_EQ});
      check("nochain_eq_ignored", {13'h0, dbg_state, reg1}, {13'h0, S_ENTRY1, 16'h0001});
      check("nochain_ready", {31'h0, key_ready}, 32'h1);
`endif

      // reset during EXEC aborts the operation
      press(K_CLR);
      press_seq('{4'd1, K_ADD, 4'd2, K_EQ});
      rst_n = 1'b0;
      #1;
      check_reset_vals("abort");
      @(negedge clk);
      rst_n   = 1'b1;
      rv_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (result_valid) rv_seen++;
      end
      check("abort_no_result", 32'(rv_seen), 32'h0);
      check_reset_vals("abort_after");
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
